instruction_buffer: RTL and testbench

//  Consumer end of the instruction-fetch interface: captures instruction pairs from the fetch stage

---
 rtl/instruction_buffer.sv | 158 +++++++++++++++
 tb/tb_instruction_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_buffer.sv
// instruction_buffer: pair FIFO between the fetch stage and dual-issue decode, flushed on redirect.
// Optional IBUF_BYPASS_EN: an empty buffer forwards the incoming fetch pair straight onto issue_*.
module instruction_buffer #(
   parameter int              DEPTH = 4,
   parameter int              IW    = 32,
   parameter logic [IW-1:0]   NOP   = IW'(32'h4020_0000)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IW-1:0]              fetch_instr1,
   input  logic [IW-1:0]              fetch_instr2,
   input  logic [31:0]                fetch_pc,
   output logic                       fetch_enable,
   input  logic                       branch_flag,
   output logic [IW-1:0]              issue_instr1,
   output logic [IW-1:0]              issue_instr2,
   output logic [31:0]                issue_pc,
   output logic [1:0]                 issue_valid,
   input  logic [1:0]                 issue_take,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Head-entry progress: both instructions still pending, or only the younger one.
   typedef enum logic {
      HEAD_PAIR   = 1'b0,
      HEAD_SECOND = 1'b1
   } head_state_t;

   head_state_t      r_state;
   head_state_t      w_state_next;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [IW-1:0]    r_mem_i1 [DEPTH];
   logic [IW-1:0]    r_mem_i2 [DEPTH];
   logic [31:0]      r_mem_pc [DEPTH];

   logic             w_empty;
   logic             w_full;
   logic             w_push_req;
   logic             w_bypass;
   logic             w_take_legal;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_avail;
   logic [1:0]       w_take;

   // Fetch side: a pair is transferred on any posedge where fetch_enable is high and no redirect
   // is in flight. Issue side: issue_valid advertises 0/1/2 slots; issue_take (<= slot count) is
   // the number consumed on that posedge. No path exists from issue_take to fetch_enable.
   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == CW'(DEPTH));
   assign fetch_enable = !reset && (!w_full || branch_flag);
   assign w_push_req   = fetch_enable && !branch_flag;

`ifdef IBUF_BYPASS_EN
   assign w_bypass = w_empty && (r_state == HEAD_PAIR) && w_push_req;
`else
   assign w_bypass = 1'b0;
`endif

   always_comb begin
      w_avail = 2'd0;
      if (w_empty) begin
         w_avail = w_bypass ? 2'd2 : 2'd0;
      end else if (r_state == HEAD_PAIR) begin
         w_avail = 2'd2;
      end else begin
         w_avail = 2'd1;
      end
   end

   assign w_take_legal = (issue_take <= w_avail);
   assign w_take       = (reset || branch_flag || !w_take_legal) ? 2'd0 : issue_take;

   assign w_pop  = !w_empty &&
                   (((w_take == 2'd2) && (r_state == HEAD_PAIR)) ||
                    ((w_take == 2'd1) && (r_state == HEAD_SECOND)));
   // A bypassed pair fully consumed in the same cycle never needs to be stored.
   assign w_push = w_push_req && !(w_bypass && (w_take == 2'd2));

   always_comb begin
      w_state_next = r_state;
      if (branch_flag) begin
         w_state_next = HEAD_PAIR;
      end else if (w_take == 2'd1) begin
         w_state_next = (r_state == HEAD_PAIR) ? HEAD_SECOND : HEAD_PAIR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= HEAD_PAIR;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || branch_flag) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_i1[r_wr_ptr] <= fetch_instr1;
         r_mem_i2[r_wr_ptr] <= fetch_instr2;
         r_mem_pc[r_wr_ptr] <= fetch_pc;
      end
   end

   always_comb begin
      issue_valid  = 2'b00;
      issue_instr1 = NOP;
      issue_instr2 = NOP;
      issue_pc     = '0;
      if (w_bypass) begin
         issue_valid  = 2'b11;
         issue_instr1 = fetch_instr1;
         issue_instr2 = fetch_instr2;
         issue_pc     = fetch_pc;
      end else if (!w_empty) begin
         issue_pc = r_mem_pc[r_rd_ptr];
         if (r_state == HEAD_PAIR) begin
            issue_valid  = 2'b11;
            issue_instr1 = r_mem_i1[r_rd_ptr];
            issue_instr2 = r_mem_i2[r_rd_ptr];
         end else begin
            issue_valid  = 2'b01;
            issue_instr1 = r_mem_i2[r_rd_ptr];
         end
      end
   end

   assign occupancy = r_count;

   a_take_legal: assert property (@(posedge clk) disable iff (reset || branch_flag) w_take_legal);
   a_valid_mask: assert property (@(posedge clk) disable iff (reset) issue_valid != 2'b10);

endmodule

// File: tb/tb_instruction_buffer.sv
// Bench for instruction_buffer: directed literal checks plus randomized traffic against a queue model.
module tb_instruction_buffer;

   localparam int          DEPTH = 4;
   localparam int          IW    = 32;
   localparam logic [31:0] NOP   = 32'h4020_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetch_instr1, fetch_instr2, fetch_pc;
   logic        fetch_enable;
   logic        branch_flag;
   logic [31:0] issue_instr1, issue_instr2, issue_pc;
   logic [1:0]  issue_valid;
   logic [1:0]  issue_take;
   logic [2:0]  occupancy;

   // clock / reset
   always #5 clk = ~clk;

   instruction_buffer #(.DEPTH(DEPTH), .IW(IW), .NOP(NOP)) dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_instr1 (fetch_instr1),
      .fetch_instr2 (fetch_instr2),
      .fetch_pc     (fetch_pc),
      .fetch_enable (fetch_enable),
      .branch_flag  (branch_flag),
      .issue_instr1 (issue_instr1),
      .issue_instr2 (issue_instr2),
      .issue_pc     (issue_pc),
      .issue_valid  (issue_valid),
      .issue_take   (issue_take),
      .occupancy    (occupancy)
   );

   // scoreboard: stored pairs packed as {instr1, instr2, pc}, oldest first
   logic [95:0] exp_q[$];
   bit          m_half = 1'b0;
   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // What issue_* / fetch_enable must show for the current model contents and inputs.
   task automatic model_view(input bit rst, input bit br, output bit fe, output logic [1:0] v,
                             output logic [31:0] i1, output logic [31:0] i2, output logic [31:0] pc);
      logic [95:0] h;
      bit          push;
      fe   = !rst && ((exp_q.size() < DEPTH) || br);
      push = fe && !br;
      v = 2'b00; i1 = NOP; i2 = NOP; pc = 32'h0;
      if (exp_q.size() > 0) begin
         h  = exp_q[0];
         pc = h[31:0];
         if (!m_half) begin
            v = 2'b11; i1 = h[95:64]; i2 = h[63:32];
         end else begin
            v = 2'b01; i1 = h[63:32];
         end
      end
`ifdef IBUF_BYPASS_EN
      else if (push) begin
         v = 2'b11; i1 = fetch_instr1; i2 = fetch_instr2; pc = fetch_pc;
      end
`else
      else if (push) begin
         v = 2'b00;
      end
`endif
   endtask

   // Apply one clock edge to the model using the inputs currently applied.
   task automatic model_step();
      bit fe; logic [1:0] v; logic [31:0] i1, i2, pc;
      model_view(reset, branch_flag, fe, v, i1, i2, pc);
      if (reset || branch_flag) begin
         exp_q.delete();
         m_half = 1'b0;
      end else if (exp_q.size() > 0) begin
         if (issue_take == 2'd2) begin
            exp_q.delete(0);
         end else if (issue_take == 2'd1) begin
            if (m_half) begin
               exp_q.delete(0);
               m_half = 1'b0;
            end else begin
               m_half = 1'b1;
            end
         end
         if (fe) exp_q.push_back({fetch_instr1, fetch_instr2, fetch_pc});
      end else if (fe) begin
`ifdef IBUF_BYPASS_EN
         if (issue_take != 2'd2) begin
            exp_q.push_back({fetch_instr1, fetch_instr2, fetch_pc});
            if (issue_take == 2'd1) m_half = 1'b1;
         end
`else
         exp_q.push_back({fetch_instr1, fetch_instr2, fetch_pc});
`endif
      end
   endtask

   // compare process: outputs are stable mid-cycle, model advances for the coming edge
   always @(negedge clk) begin : cmp_proc
      bit fe; logic [1:0] v; logic [31:0] i1, i2, pc;
      model_view(reset, branch_flag, fe, v, i1, i2, pc);
      if (chk_en) begin
         check("fetch_enable", {31'b0, fetch_enable}, {31'b0, fe});
         check("issue_valid", {30'b0, issue_valid}, {30'b0, v});
         check("issue_instr1", issue_instr1, i1);
         check("issue_instr2", issue_instr2, i2);
         check("issue_pc", issue_pc, pc);
         check("occupancy", {29'b0, occupancy}, 32'(exp_q.size()));
      end
      model_step();
   end

   // driver tasks
   task automatic set_in(input logic [1:0] take, input logic br, input logic [31:0] pc);
      issue_take   = take;
      branch_flag  = br;
      fetch_pc     = pc;
      fetch_instr1 = 32'hA000_0000 | pc;
      fetch_instr2 = 32'hB000_0000 | pc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit fe; logic [1:0] v; logic [31:0] i1, i2, pc;
      int vc, phase;
      logic [1:0] tk;

      reset = 1'b1;
      set_in(2'd0, 1'b0, 32'd0);
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_valid", {30'b0, issue_valid}, 32'd0);
      check("rst_instr1", issue_instr1, NOP);
      check("rst_instr2", issue_instr2, NOP);
      check("rst_pc", issue_pc, 32'd0);
      check("rst_occ", {29'b0, occupancy}, 32'd0);
      check("rst_fe", {31'b0, fetch_enable}, 32'd0);

      // three pushes, nothing taken
      reset = 1'b0;
      set_in(2'd0, 1'b0, 32'd8);  tick();
      set_in(2'd0, 1'b0, 32'd16); tick();
      set_in(2'd0, 1'b0, 32'd24); tick();
      set_in(2'd0, 1'b0, 32'd32); #1;
      check("fill3_occ", {29'b0, occupancy}, 32'd3);
      check("fill3_pc", issue_pc, 32'd8);
      check("fill3_valid", {30'b0, issue_valid}, 32'd3);
      check("fill3_fe", {31'b0, fetch_enable}, 32'd1);

      // full: fetch stalls and occupancy holds
      tick();
      set_in(2'd0, 1'b0, 32'd40); #1;
      check("full_fe", {31'b0, fetch_enable}, 32'd0);
      check("full_occ", {29'b0, occupancy}, 32'd4);
      tick();
      check("full_hold_occ", {29'b0, occupancy}, 32'd4);

      // take=2 frees a slot
      set_in(2'd2, 1'b0, 32'd40); tick();
      set_in(2'd0, 1'b0, 32'd40); #1;
      check("drain_fe", {31'b0, fetch_enable}, 32'd1);
      check("drain_occ", {29'b0, occupancy}, 32'd3);
      check("drain_pc", issue_pc, 32'd16);

      // single takes walk through the head pair
      set_in(2'd1, 1'b0, 32'd40); tick();
      set_in(2'd0, 1'b0, 32'd48); #1;
      check("half_valid", {30'b0, issue_valid}, 32'd1);
      check("half_instr1", issue_instr1, 32'hB000_0010);
      check("half_instr2", issue_instr2, NOP);
      check("half_pc", issue_pc, 32'd16);
      set_in(2'd1, 1'b0, 32'd48); tick();
      set_in(2'd0, 1'b0, 32'd48); #1;
      check("adv_valid", {30'b0, issue_valid}, 32'd3);
      check("adv_pc", issue_pc, 32'd24);
      check("adv_instr1", issue_instr1, 32'hA000_0018);

      // redirect with a concurrent take=2 at occupancy 3
      set_in(2'd2, 1'b1, 32'd48); tick();
      set_in(2'd0, 1'b0, 32'd100); #1;
      check("flush_occ", {29'b0, occupancy}, 32'd0);
      check("flush_fe", {31'b0, fetch_enable}, 32'd1);
`ifdef IBUF_BYPASS_EN
      check("flush_bypass_pc", issue_pc, 32'd100);
`else
      check("flush_valid", {30'b0, issue_valid}, 32'd0);
`endif
      tick();
      set_in(2'd0, 1'b0, 32'd108); #1;
      check("target_occ", {29'b0, occupancy}, 32'd1);
      check("target_pc", issue_pc, 32'd100);

      // push + take=2 at occupancy 2 across the write-pointer wrap
      tick();
      set_in(2'd2, 1'b0, 32'd116); tick();
      set_in(2'd2, 1'b0, 32'd124); tick();
      set_in(2'd2, 1'b0, 32'd132); tick();
      set_in(2'd0, 1'b0, 32'd140); #1;
      check("wrap_occ", {29'b0, occupancy}, 32'd2);
      check("wrap_pc", issue_pc, 32'd124);
      tick();
      set_in(2'd2, 1'b0, 32'd148); tick();
      set_in(2'd0, 1'b0, 32'd156); #1;
      check("wrap_head_pc", issue_pc, 32'd132);
      check("wrap_head_i1", issue_instr1, 32'hA000_0084);
      check("wrap_head_i2", issue_instr2, 32'hB000_0084);
      check("wrap_head_occ", {29'b0, occupancy}, 32'd3);

      // empty buffer meets a fresh fetch pair
      set_in(2'd0, 1'b1, 32'd0); tick();
`ifdef IBUF_BYPASS_EN
      set_in(2'd2, 1'b0, 32'd200); #1;
      check("byp_valid", {30'b0, issue_valid}, 32'd3);
      check("byp_instr1", issue_instr1, 32'hA000_00C8);
      check("byp_pc", issue_pc, 32'd200);
      tick();
      set_in(2'd0, 1'b0, 32'd208); #1;
      check("byp_occ", {29'b0, occupancy}, 32'd0);
`else
      set_in(2'd0, 1'b0, 32'd200); #1;
      check("nobyp_valid", {30'b0, issue_valid}, 32'd0);
      check("nobyp_occ", {29'b0, occupancy}, 32'd0);
      tick();
      set_in(2'd0, 1'b0, 32'd208); #1;
      check("nobyp_next_valid", {30'b0, issue_valid}, 32'd3);
      check("nobyp_next_pc", issue_pc, 32'd200);
`endif

      // randomized traffic; phases bias toward filling, draining or mixed consumption
      phase = 0;
      for (int c = 0; c < 3000; c++) begin
         if ((c % 64) == 0) phase = int'($urandom_range(0, 2));
         reset        = ($urandom_range(0, 149) == 0);
         branch_flag  = ($urandom_range(0, 19) == 0);
         fetch_instr1 = $urandom;
         fetch_instr2 = $urandom;
         fetch_pc     = $urandom & 32'hFFFF_FFF8;
         model_view(reset, branch_flag, fe, v, i1, i2, pc);
         vc = (v == 2'b11) ? 2 : (v == 2'b01) ? 1 : 0;
         case (phase)
            0:       tk = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, vc)) : 2'd0;
            1:       tk = 2'(vc);
            default: tk = 2'($urandom_range(0, vc));
         endcase
         issue_take = tk;
         tick();
      end

      reset = 1'b0;
      set_in(2'd0, 1'b0, 32'd0);
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
